// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first request strictly after ptr, wrapping.
// Zero latency; grant is all-zero when no request is present.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_req
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    any_req = |req;
    // The requester at ptr is scanned last, giving it lowest priority.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte sources; tx_en one cycle after accept.
// One accept per frame; req_ready held low until tx_done (or watchdog abort) returns to IDLE.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W,
  parameter int TIMEOUT = 1048576
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_en,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

  arb_state_t        state_q;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  grant_id_q;
  logic              tx_en_q;
  logic              timeout_err_q;
  logic [WD_W-1:0]   wd_cnt_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               accept;
  logic [DATA_W-1:0]  sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  // arst gates the combinational ready so it is low for the whole reset window.
  assign accept    = !arst && (state_q == IDLE) && enable && !tx_busy && arb_any;
  assign req_ready = accept ? arb_gnt : '0;
  assign sel_data  = req_data[int'(arb_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= IDLE;
      data_q        <= '0;
      rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
      grant_id_q    <= '0;
      tx_en_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q     <= sel_data;
            rr_ptr_q   <= arb_idx;
            grant_id_q <= arb_idx;
            tx_en_q    <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_en_q  <= 1'b0;
          wd_cnt_q <= '0;
          state_q  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            state_q <= IDLE;
          end else begin
            if (wd_cnt_q != '1) wd_cnt_q <= wd_cnt_q + 1'b1;
            if (TIMEOUT != 0 && wd_cnt_q == WD_LAST) begin
              timeout_err_q <= 1'b1;
              state_q       <= IDLE;
            end
          end
        end
        default: begin
          tx_en_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_en       = tx_en_q;
  assign tx_data     = data_q;
  assign grant_id    = grant_id_q;
  assign arb_busy    = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Random and directed stimulus for uart_tx_arbiter checked against a cycle-level reference model.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           arst;
  logic           enable;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           tx_en;
  logic [DW-1:0]  tx_data;
  logic           tx_busy;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           arb_busy;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  // reference model: 0 idle, 1 launching, 2 waiting for the frame to end
  int          m_phase, m_last, m_gid, m_waited;
  logic [7:0]  m_data;
  bit          m_err;

  // uart emulation
  int u_left, u_tail, u_delay;
  bit u_rand;

  int cyc, en_cyc, to_cyc, to_cnt;
  int glog[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .arst(arst), .enable(enable), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id), .arb_busy(arb_busy),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Winner of a fair rotation: first valid requester after the previous winner.
  function automatic int pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_last = NR - 1; m_gid = 0; m_waited = 0; m_data = 8'h00; m_err = 0;
    u_left = -1; u_tail = 0;
  endtask

  // Entered at posedge+1 with enable/req_* already set; leaves at next posedge+1.
  task automatic step(input string tag);
    int w;
    tx_done = (u_left == 0);
    tx_busy = (u_left >= 0) || (u_tail > 0);
    #4;
    w = (m_phase == 0 && enable && !tx_busy) ? pick(req_valid, m_last) : -1;
    check({tag, ".ready"},  32'(req_ready), (w >= 0) ? 32'(1 << w) : 32'd0);
    check({tag, ".tx_en"},  32'(tx_en), 32'(m_phase == 1));
    check({tag, ".tx_data"}, 32'(tx_data), 32'(m_data));
    check({tag, ".grant_id"}, 32'(grant_id), 32'(m_gid));
    check({tag, ".busy"},   32'(arb_busy), 32'(m_phase != 0));
    check({tag, ".tmo"},    32'(timeout_err), 32'(m_err));
    if (req_ready != 0) glog.push_back(oh2idx(req_ready));
    if (tx_en === 1'b1) en_cyc = cyc;
    if (timeout_err === 1'b1) begin to_cyc = cyc; to_cnt++; end

    m_err = 0;
    case (m_phase)
      0: if (w >= 0) begin
        m_data = req_data[w*DW +: DW]; m_last = w; m_gid = w; m_phase = 1;
      end
      1: begin m_phase = 2; m_waited = 0; end
      default: begin
        if (tx_done) m_phase = 0;
        else if (m_waited == TO - 1) begin m_err = 1; m_phase = 0; end
        else m_waited++;
      end
    endcase

    if (tx_en === 1'b1) begin
      if (u_rand) u_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
      if (u_delay >= 0) u_left = u_delay;
    end else if (u_left == 0) begin
      u_left = -1;
      u_tail = u_rand ? int'($urandom_range(0, 2)) : 0;
    end else if (u_left > 0) u_left--;
    else if (u_tail > 0) u_tail--;

    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    arst = 1'b1; #1; arst = 1'b0; #1;
    model_reset();
    glog.delete();
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int b = 0;
    while (glog.size() < n && b < budget) begin step(tag); b++; end
    check({tag, ".bound"}, 32'(glog.size() >= n), 32'd1);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    arst = 1'b1; enable = 1'b0; req_valid = '0; req_data = '0;
    tx_busy = 1'b0; tx_done = 1'b0; u_rand = 0; u_delay = 5;
    cyc = 0; en_cyc = -100; to_cyc = -100; to_cnt = 0;
    model_reset();
    #2;
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.tx_en", 32'(tx_en), 32'd0);
    check("rst.tx_data", 32'(tx_data), 32'd0);
    check("rst.grant_id", 32'(grant_id), 32'd0);
    check("rst.busy", 32'(arb_busy), 32'd0);
    check("rst.tmo", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    arst = 1'b0;

    // single requester, byte 0x55
    enable = 1'b1; req_valid = 4'b0001; req_data = 32'h0000_0055;
    run_until("t1", 1, 10);
    req_valid = '0;
    #1;
    check("t1.first_idx", 32'(glog[0]), 32'd0);
    check("t1.tx_en", 32'(tx_en), 32'd1);
    check("t1.tx_data", 32'(tx_data), 32'h55);
    run("t1", 12);

    // all requesters, long frames: strict rotation
    reset_dut();
    req_valid = 4'b1111; req_data = 32'hD4C3_B2A1; u_delay = 19;
    run_until("t2", 5, 300);
    for (int i = 0; i < 5; i++) check("t2.order", 32'(glog[i]), 32'(i % NR));

    // after granting 2, requesters 0 and 2 compete: 0 wins
    reset_dut();
    u_delay = 3; req_valid = 4'b0100;
    run_until("t3", 1, 10);
    req_valid = 4'b0101;
    run_until("t3", 2, 40);
    check("t3.g0", 32'(glog[0]), 32'd2);
    check("t3.g1", 32'(glog[1]), 32'd0);

    // uart never completes: watchdog abort, then a fresh accept
    reset_dut();
    u_delay = -1; to_cnt = 0; req_valid = 4'b0001;
    run_until("t4", 1, 10);
    req_valid = '0;
    run("t4", 25);
    check("t4.tmo_count", 32'(to_cnt), 32'd1);
    check("t4.tmo_delay", 32'(to_cyc - en_cyc), 32'(TO + 1));
    req_valid = 4'b0010;
    run_until("t4", 2, 10);
    check("t4.next", 32'(glog[1]), 32'd1);

    // enable drops mid-frame: frame completes, no accept until re-enabled
    reset_dut();
    u_delay = 8; req_valid = 4'b1111;
    run_until("t5", 1, 10);
    enable = 1'b0;
    run("t5", 30);
    check("t5.held", 32'(glog.size()), 32'd1);
    enable = 1'b1;
    run_until("t5", 2, 10);
    check("t5.next", 32'(glog[1]), 32'd1);

    // async reset mid-frame
    reset_dut();
    u_delay = 10; req_valid = 4'b0010; req_data = 32'h0000_A700;
    run_until("t6", 1, 10);
    run("t6", 4);
    req_valid = 4'b1111;
    arst = 1'b1; #1;
    check("t6.ready", 32'(req_ready), 32'd0);
    check("t6.tx_en", 32'(tx_en), 32'd0);
    check("t6.tx_data", 32'(tx_data), 32'd0);
    check("t6.grant_id", 32'(grant_id), 32'd0);
    check("t6.busy", 32'(arb_busy), 32'd0);
    check("t6.tmo", 32'(timeout_err), 32'd0);
    arst = 1'b0; #1;
    model_reset(); glog.delete();
    run_until("t6", 1, 5);
    check("t6.prio", 32'(glog[0]), 32'd0);

    // randomized traffic
    reset_dut();
    u_rand = 1;
    for (int i = 0; i < 2500; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      req_valid = NR'($urandom());
      req_data  = $urandom();
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
